// File: rtl/fpu_scoreboard.sv
// FP issue scoreboard: tracks up to four in-flight register writes by latency slot,
// stalls on RAW/WAW hazards and writeback-port conflicts, and signals retirement.
module fpu_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        reg_write,
  input  logic        is_hazard_0,
  input  logic        is_hazard_1,
  input  logic        is_hazard_2,
  output logic        stall,
  output logic        issue_accept,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] busy,
  output logic [15:0] stall_count
);

  logic [3:0]      slot_valid_q, slot_valid_d;
  logic [3:0][4:0] slot_rd_q, slot_rd_d;
  logic [1:0]      lat;
  logic            port_conflict, raw_hit, waw_hit;

  always_comb begin
    if (is_hazard_2)      lat = 2'd3;
    else if (is_hazard_1) lat = 2'd2;
    else if (is_hazard_0) lat = 2'd1;
    else                  lat = 2'd0;
  end

  // After the shift, slot[L+1] lands in slot[L], which this issue would claim.
  always_comb begin
    unique case (lat)
      2'd0:    port_conflict = slot_valid_q[1];
      2'd1:    port_conflict = slot_valid_q[2];
      2'd2:    port_conflict = slot_valid_q[3];
      default: port_conflict = 1'b0;
    endcase
    port_conflict = port_conflict & reg_write;
  end

  // Slot 0 is excluded: its result is bypassed by the register file this cycle.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (slot_valid_q[k]) begin
        if (use_rs1 && (issue_rs1 == slot_rd_q[k])) raw_hit = 1'b1;
        if (use_rs2 && (issue_rs2 == slot_rd_q[k])) raw_hit = 1'b1;
        if (reg_write && (issue_rd == slot_rd_q[k])) waw_hit = 1'b1;
      end
    end
  end

  assign stall        = issue_valid & (port_conflict | raw_hit | waw_hit);
  assign issue_accept = issue_valid & ~stall;

  always_comb begin
    slot_valid_d = {1'b0, slot_valid_q[3:1]};
    slot_rd_d    = {5'd0, slot_rd_q[3:1]};
    if (issue_accept && reg_write) begin
      slot_valid_d[lat] = 1'b1;
      slot_rd_d[lat]    = issue_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_rd_q    <= '0;
      stall_count  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_rd_q    <= slot_rd_d;
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < 4; k++) begin
      if (slot_valid_q[k]) busy[slot_rd_q[k]] = 1'b1;
    end
  end

  assign wb_valid = slot_valid_q[0];
  assign wb_rd    = slot_rd_q[0];

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed, table-driven bench for fpu_scoreboard plus hand-written reset and
// saturation sequences.
module tb_fpu_scoreboard;

  logic        clk, rst;
  logic        issue_valid, use_rs1, use_rs2, reg_write;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        is_hazard_0, is_hazard_1, is_hazard_2;
  logic        stall, issue_accept, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  fpu_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .reg_write   (reg_write),
    .is_hazard_0 (is_hazard_0),
    .is_hazard_1 (is_hazard_1),
    .is_hazard_2 (is_hazard_2),
    .stall       (stall),
    .issue_accept(issue_accept),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .busy        (busy),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, rw;
    int          lat;
    logic        e_stall, e_acc, e_wbv;
    logic [4:0]  e_wbrd;
    logic [31:0] e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic rw, int lat, logic e_stall,
                              logic e_acc, logic e_wbv, logic [4:0] e_wbrd,
                              logic [31:0] e_busy, logic [15:0] e_cnt);
    vec_t v;
    v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rw = rw;
    v.lat = lat; v.e_stall = e_stall; v.e_acc = e_acc; v.e_wbv = e_wbv;
    v.e_wbrd = e_wbrd; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic vec_t idle(logic e_wbv, logic [4:0] e_wbrd, logic [31:0] e_busy,
                                logic [15:0] e_cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_wbv, e_wbrd, e_busy, e_cnt);
  endfunction

  task automatic drive(logic iv, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                       logic u1, logic u2, logic rw, int lat);
    issue_valid = iv;  issue_rd = rd;  issue_rs1 = rs1;  issue_rs2 = rs2;
    use_rs1 = u1;  use_rs2 = u2;  reg_write = rw;
    is_hazard_0 = (lat >= 1);
    is_hazard_1 = (lat >= 2);
    is_hazard_2 = (lat >= 3);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Latency, RAW bypass, port conflict, no-write, WAW, f0 and issue_valid=0 cases.
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0));        // 0 fmul rd5
    vecs.push_back(idle(0, 0, 32'h1 << 5, 0));
    vecs.push_back(idle(0, 0, 32'h1 << 5, 0));
    vecs.push_back(idle(1, 5, 32'h1 << 5, 0));                          // 3 wb 5
    vecs.push_back(idle(0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 2, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0));        // 5 fadd rd3
    vecs.push_back(mk(1, 8, 3, 0, 1, 0, 1, 1, 1, 0, 0, 0, 32'h1 << 3, 0)); // RAW stall
    vecs.push_back(mk(1, 8, 3, 0, 1, 0, 1, 1, 0, 1, 1, 3, 32'h1 << 3, 1)); // bypass
    vecs.push_back(idle(0, 0, 32'h1 << 8, 1));
    vecs.push_back(idle(1, 8, 32'h1 << 8, 1));
    vecs.push_back(mk(1, 4, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1));        // 10 fmul rd4
    vecs.push_back(mk(1, 6, 10, 0, 1, 0, 1, 1, 1, 0, 0, 0, 32'h1 << 4, 1)); // port stall
    vecs.push_back(mk(1, 6, 10, 0, 1, 0, 1, 1, 0, 1, 0, 0, 32'h1 << 4, 2));
    vecs.push_back(idle(1, 4, (32'h1 << 4) | (32'h1 << 6), 2));
    vecs.push_back(idle(1, 6, 32'h1 << 6, 2));
    vecs.push_back(idle(0, 0, 0, 2));
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 2));        // 16 rd9 L3
    vecs.push_back(mk(1, 9, 12, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h1 << 9, 2)); // ftoi
    vecs.push_back(idle(0, 0, 32'h1 << 9, 2));
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 32'h1 << 9, 2)); // WAW stall
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 1, 2, 0, 1, 1, 9, 32'h1 << 9, 3));
    vecs.push_back(idle(0, 0, 32'h1 << 9, 3));
    vecs.push_back(idle(0, 0, 32'h1 << 9, 3));
    vecs.push_back(idle(1, 9, 32'h1 << 9, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3));        // 24 f0
    vecs.push_back(idle(1, 0, 32'h1, 3));
    vecs.push_back(mk(1, 11, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 3));       // 26 rd11 L3
    vecs.push_back(mk(0, 11, 11, 0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h1 << 11, 3)); // iv=0
    vecs.push_back(mk(1, 11, 11, 0, 1, 0, 1, 0, 1, 0, 0, 0, 32'h1 << 11, 3));
    vecs.push_back(idle(0, 0, 32'h1 << 11, 4));
    vecs.push_back(idle(1, 11, 32'h1 << 11, 4));
    vecs.push_back(idle(0, 0, 0, 4));

    // Reset values, with an issue presented against empty slots.
    rst = 1'b1;
    drive(1, 2, 2, 2, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", stall_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rw, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_accept", i), issue_accept, vecs[i].e_acc);
      chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_wbv);
      if (vecs[i].e_wbv) chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].e_wbrd);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_count", i), stall_count, vecs[i].e_cnt);
      next_cycle();
    end

    // Reset mid-flight: rd7 must never retire; asynchronous clear between edges.
    drive(1, 7, 0, 0, 0, 0, 1, 2);
    @(negedge clk);
    chk("mid_accept", issue_accept, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("pre_rst_busy", busy, 32'h1 << 7);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_count", stall_count, 0);
    chk("async_wb_valid", wb_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 13, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("first_accept", issue_accept, 1);
    chk("first_busy", busy, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("first_wb_valid", wb_valid, 1);
    chk("first_wb_rd", wb_rd, 13);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("post_rst%0d_busy", i), busy, 0);
      chk($sformatf("post_rst%0d_wb_valid", i), wb_valid, 0);
    end

    // Saturation: a self-dependent L=3 issue stalls three of every four cycles.
    next_cycle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1, 4, 4, 0, 1, 0, 1, 3);
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("sat_partial", stall_count, 300);
    repeat (87000) @(posedge clk);
    @(negedge clk);
    chk("sat_full", stall_count, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
